// File: rtl/gpu_pkg.sv
// Shared GPU definitions: scanline defaults, colour constants and scanout state encoding.
package gpu_pkg;

    localparam int unsigned LINE_WIDTH_DEFAULT = 240;
    localparam logic [15:0] WHITE_BGR555       = 16'h7FFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scanout_skid.sv
// Two-entry skid FIFO with valid/ready on both sides; head entry drives out_data directly.
module scanout_skid
    import gpu_pkg::*;
#(
    parameter int unsigned WIDTH = 25
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head, tail;
    logic             push, pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_data;
                    else               tail <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/line_scanout.sv
// Streams one scanline from a double-buffered line RAM to a valid/ready pixel port.
// Optional macro LINE_SCANOUT_BLANK_EN adds force_blank (white line, sampled on start).
module line_scanout
    import gpu_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEFAULT,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  buf_sel,
`ifdef LINE_SCANOUT_BLANK_EN
    input  logic                  force_blank,
`endif
    output logic [ADDR_WIDTH:0]   raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic [ADDR_WIDTH-1:0] pix_x,
    output logic                  pix_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned           FW       = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LINE_WIDTH - 1);

    scan_state_t           state, state_nxt;
    logic [ADDR_WIDTH-1:0] rd_idx, idx_issue, inflight_x;
    logic [ADDR_WIDTH:0]   raddr_q;
    logic                  half_q, half_issue, blank_q, blank_nxt, blank_in;
    logic                  issue, inflight, inflight_last, accept, room;
    logic [1:0]            fifo_count;
    logic [2:0]            occ;
    logic                  fifo_in_ready, fifo_out_valid;
    logic [FW-1:0]         fifo_in, fifo_out;
    logic [DATA_WIDTH-1:0] push_data;

`ifdef LINE_SCANOUT_BLANK_EN
    assign blank_in = force_blank;
`else
    assign blank_in = 1'b0;
`endif

    assign accept = pix_valid & pix_ready;
    // Occupancy is taken after this cycle's pop so a steady ready sustains one read per cycle.
    assign occ  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, accept};
    assign room = (occ < 3'd2);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        idx_issue  = rd_idx;
        half_issue = half_q;
        blank_nxt  = blank_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    issue      = 1'b1;
                    idx_issue  = '0;
                    half_issue = buf_sel;
                    blank_nxt  = blank_in;
                    state_nxt  = (LINE_WIDTH == 1) ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (room) begin
                    issue = 1'b1;
                    if (rd_idx == LAST_IDX) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept && pix_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The first read goes out in the start cycle itself, giving pixel 0 two cycles after start.
    assign raddr = issue ? {half_issue, idx_issue} : raddr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_idx        <= '0;
            raddr_q       <= '0;
            half_q        <= 1'b0;
            blank_q       <= 1'b0;
            inflight      <= 1'b0;
            inflight_x    <= '0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            half_q   <= half_issue;
            blank_q  <= blank_nxt;
            inflight <= issue;
            done     <= accept & pix_last;
            if (issue) begin
                raddr_q       <= {half_issue, idx_issue};
                rd_idx        <= idx_issue + ADDR_WIDTH'(1);
                inflight_x    <= idx_issue;
                inflight_last <= (idx_issue == LAST_IDX);
            end
        end
    end

    assign push_data = blank_q ? DATA_WIDTH'(WHITE_BGR555) : rdata;
    assign fifo_in   = {inflight_last, inflight_x, push_data};

    scanout_skid #(.WIDTH(FW)) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (inflight & fifo_in_ready),
        .in_ready  (fifo_in_ready),
        .in_data   (fifo_in),
        .out_valid (fifo_out_valid),
        .out_ready (pix_ready),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

    assign pix_valid = fifo_out_valid;
    assign pix_data  = fifo_out[DATA_WIDTH-1:0];
    assign pix_x     = fifo_out[DATA_WIDTH +: ADDR_WIDTH];
    assign pix_last  = fifo_out_valid & fifo_out[FW-1];
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_line_scanout.sv
// Directed self-checking bench for line_scanout with a registered line-RAM model.
module tb_line_scanout;

    localparam int M_FULL    = 0;
    localparam int M_RAND    = 1;
    localparam int M_STALL   = 2;
    localparam int M_RESTART = 3;
    localparam int M_RESET   = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        buf_sel;
`ifdef LINE_SCANOUT_BLANK_EN
    logic        force_blank;
`endif
    logic [8:0]  raddr;
    logic [15:0] rdata;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic [7:0]  pix_x;
    logic        pix_last;
    logic        busy;
    logic        done;

    logic [15:0] mem [512];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];

    line_scanout dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .buf_sel     (buf_sel),
`ifdef LINE_SCANOUT_BLANK_EN
        .force_blank (force_blank),
`endif
        .raddr       (raddr),
        .rdata       (rdata),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_last    (pix_last),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_line(input logic sel, input int mode, input logic blank);
        int          exp_x, issued, accepted, cyc, stall_left, done_cnt;
        logic [8:0]  last_raddr;
        logic [15:0] prev_data, exp_data;
        logic [7:0]  prev_x, xb;
        logic        prev_last, prev_stall, restart_pending, hs, finished;
        exp_x = 0; issued = 0; accepted = 0; cyc = 0; stall_left = 0; done_cnt = 0;
        prev_stall = 1'b0; restart_pending = 1'b0; finished = 1'b0;
        prev_data = '0; prev_x = '0; prev_last = 1'b0;

        @(posedge clk); #1;
        start = 1'b1; buf_sel = sel; pix_ready = 1'b1;
`ifdef LINE_SCANOUT_BLANK_EN
        force_blank = blank;
`endif
        #1;
        chk("raddr_first", raddr, {sel, 8'h00});
        chk("busy_before_start", busy, 1'b0);
        issued = 1; last_raddr = raddr;

        while (!finished && cyc < 3000) begin
            @(posedge clk); #1;
            start   = restart_pending;
            buf_sel = restart_pending ? ~sel : sel;
            restart_pending = 1'b0;
            if (mode == M_RAND)       pix_ready = 1'($urandom_range(0, 1));
            else if (stall_left > 0) begin pix_ready = 1'b0; stall_left--; end
            else                      pix_ready = 1'b1;
            #1;
            hs = pix_valid & pix_ready;
            if (cyc == 0) chk("latency_c1_valid", pix_valid, 1'b0);
            if (cyc == 1) chk("latency_c2_valid", pix_valid, 1'b1);
            if (done) done_cnt++;

            if (mode == M_RESET && pix_valid && pix_x == 8'd120) begin
                resetn = 1'b0;
                #1;
                chk("rst_pix_valid", pix_valid, 1'b0);
                chk("rst_pix_last", pix_last, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_pix_x", pix_x, 8'h00);
                chk("rst_pix_data", pix_data, 16'h0000);
                chk("rst_raddr", raddr, 9'h000);
                @(posedge clk); @(posedge clk); #1;
                resetn = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk); #2;
                    chk("post_rst_no_valid", pix_valid, 1'b0);
                end
                return;
            end

            if (raddr !== last_raddr) begin
                chk("raddr_seq", raddr, {sel, 8'(issued)});
                issued++;
                last_raddr = raddr;
            end
            chk("reads_ahead_le2", (issued - accepted - int'(hs)) <= 2, 1'b1);

            if (prev_stall) begin
                chk("stall_keep_valid", pix_valid, 1'b1);
                chk("stall_keep_x", pix_x, prev_x);
                chk("stall_keep_data", pix_data, prev_data);
                chk("stall_keep_last", pix_last, prev_last);
            end
            if (pix_valid) begin
                xb = 8'(exp_x);
                exp_data = blank ? 16'h7FFF : mem[{sel, xb}];
                chk("pix_x", pix_x, xb);
                chk("pix_data", pix_data, exp_data);
                chk("pix_last", pix_last, exp_x == 239);
            end
            prev_stall = pix_valid & ~pix_ready;
            prev_x = pix_x; prev_data = pix_data; prev_last = pix_last;

            if (hs) begin
                accepted++;
                if (mode == M_STALL && exp_x == 5)     stall_left = 20;
                if (mode == M_RESTART && exp_x == 100) restart_pending = 1'b1;
                exp_x++;
                if (exp_x == 240) finished = 1'b1;
            end
            cyc++;
        end

        chk("line_pixel_count", exp_x, 240);
        chk("line_read_count", issued, 240);
        chk("no_done_mid_line", done_cnt, 0);
        @(posedge clk); #2;
        chk("done_after_last", done, 1'b1);
        chk("busy_falls_with_done", busy, 1'b0);
        chk("no_valid_after_line", pix_valid, 1'b0);
        @(posedge clk); #2;
        chk("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'(i * 97 + 13) ^ 16'(i << 7);
        resetn = 1'b0; start = 1'b0; buf_sel = 1'b0; pix_ready = 1'b0;
`ifdef LINE_SCANOUT_BLANK_EN
        force_blank = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        chk("reset_pix_valid", pix_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_raddr", raddr, 9'h000);
        chk("reset_pix_x", pix_x, 8'h00);
        chk("reset_pix_data", pix_data, 16'h0000);
        chk("reset_pix_last", pix_last, 1'b0);
        resetn = 1'b1;

        run_line(1'b1, M_FULL, 1'b0);
        run_line(1'b1, M_RAND, 1'b0);
        run_line(1'b1, M_STALL, 1'b0);
        run_line(1'b1, M_RESTART, 1'b0);
        run_line(1'b1, M_RESET, 1'b0);
        run_line(1'b0, M_FULL, 1'b0);
`ifdef LINE_SCANOUT_BLANK_EN
        run_line(1'b1, M_FULL, 1'b1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/line_scanout.md
LINE_SCANOUT -- requirements
Module: line_scanout

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 240, meaning visible pixels per scanline.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning line-buffer index width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, meaning pixel width (BGR555 plus spare bit).
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports: clk  in  1  clock; resetn  in  1  async active-low reset.
REQ-005 SHALL have ports: start  in  1  begin scanout of one line (pulse); buf_sel  in  1  line-buffer half to read, sampled on start.
REQ-006 SHALL have ports: raddr  out  ADDR_WIDTH+1  line-buffer read address, MSB = buffer half; rdata  in  DATA_WIDTH  line-buffer data, valid one cycle after raddr.
REQ-007 SHALL have ports: pix_valid  out  1; pix_ready  in  1; pix_data  out  DATA_WIDTH; pix_x  out  ADDR_WIDTH  pixel index; pix_last  out  1  final pixel of line.
REQ-008 SHALL have ports: busy  out  1  line in progress; done  out  1  one-cycle pulse after last pixel accepted.

Function
REQ-009 SHALL implement states IDLE, FETCH, DRAIN; IDLE->FETCH on start; FETCH->DRAIN after read LINE_WIDTH-1 issued; DRAIN->IDLE when pixel LINE_WIDTH-1 is accepted.
REQ-010 SHALL ignore start while busy=1; no restart, no corruption of the current line.
REQ-011 SHALL issue reads in ascending order 0..LINE_WIDTH-1 within buf_sel's half, at most one per cycle.
REQ-012 SHALL compensate the 1-cycle read latency via a 2-entry skid FIFO; a read is issued only if FIFO occupancy plus in-flight reads is below 2.
REQ-013 SHALL transfer a pixel only on pix_valid & pix_ready; pix_data/pix_x/pix_last held stable while pix_valid=1 and pix_ready=0.
REQ-014 SHALL sustain one pixel per cycle with pix_ready held high; first pix_valid 2 cycles after start.
REQ-015 SHALL assert pix_last exactly with pix_x = LINE_WIDTH-1.
REQ-016 SHALL pulse done one cycle after the last handshake; busy falls in the same cycle done rises.
REQ-017 SHALL hold raddr at its last value when no read is issued; no ordering constraint on raddr outside FETCH.

Reset
REQ-018 SHALL on resetn=0 asynchronously enter IDLE, empty the FIFO, clear the in-flight flag; pix_valid=0, pix_last=0, done=0, busy=0, pix_x=0, pix_data=0, raddr=0.
REQ-019 SHALL, when reset is asserted mid-line, discard the line; after release, only a new start produces output.

Configuration
REQ-020 SHALL support macro LINE_SCANOUT_BLANK_EN; when defined, input force_blank (1 bit, sampled on start) makes the line emit LINE_WIDTH pixels of white (all colour bits 1, i.e. 0x7FFF) with identical handshake timing and no rdata dependence.
REQ-021 SHALL, without LINE_SCANOUT_BLANK_EN, have no force_blank port and always output line-buffer data.

Structure
REQ-022 SHALL take LINE_WIDTH default, colour constant WHITE_BGR555 = 0x7FFF and state encoding from shared package gpu_pkg.
REQ-023 SHALL implement the skid FIFO as sub-module scanout_skid (2-deep, DATA_WIDTH+ADDR_WIDTH+1 wide, valid/ready both sides).

Verification
REQ-024 Bench SHALL cover: buf_sel=1, start, pix_ready=1 constantly -> 240 pixels, raddr 0x100..0x1EF, data matches preloaded buffer, pix_last at x=239, done 1 cycle later.
REQ-025 Bench SHALL cover: pix_ready random 50% -> identical pixel sequence, no drop/duplication, data stable while stalled.
REQ-026 Bench SHALL cover: pix_ready low 20 cycles after x=5 -> at most 2 pixels buffered, no extra reads issued, resumes at x=6.
REQ-027 Bench SHALL cover: second start at x=100 -> ignored, line completes 240 pixels, one done pulse.
REQ-028 Bench SHALL cover: resetn low at x=120 -> all outputs reset values immediately; no pix_valid until next start.
REQ-029 Bench SHALL cover, with LINE_SCANOUT_BLANK_EN: force_blank=1 at start -> 240 pixels of 0x7FFF, same timing as REQ-024.
